mem_port_arbiter: RTL and testbench

//  Shares the single-port memory (valid/ready, wt_rd, addr, wdata, rdata) between NUM_REQ agents.

---
 rtl/mem_arb_pkg.sv | 14 +
 rtl/mem_rr_picker.sv | 28 ++
 rtl/mem_port_arbiter.sv | 132 +++++++++++++
 tb/tb_mem_port_arbiter.sv | 188 ++++++++++++++++++
 4 files changed

// File: rtl/mem_arb_pkg.sv
// rtl/mem_arb_pkg.sv - shared types and width helpers for the memory port arbiter
package mem_arb_pkg;

    typedef enum logic [1:0] {IDLE, ISSUE, DONE} arb_state_e;

    function automatic int calc_idx_w(input int num_req);
        return (num_req > 1) ? $clog2(num_req) : 1;
    endfunction

    function automatic int calc_tmr_w(input int timeout);
        return $clog2(timeout + 1);
    endfunction

endpackage

// File: rtl/mem_rr_picker.sv
// rtl/mem_rr_picker.sv - combinational round-robin pick starting at rr_ptr
module mem_rr_picker #(
    parameter int NUM_REQ = 2,
    parameter int IDX_W   = 1
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   rr_ptr,
    output logic               any_req,
    output logic [IDX_W-1:0]   sel
);

    int j;

    // Walk offsets from farthest to nearest so the closest set bit wins.
    always_comb begin
        any_req = 1'b0;
        sel     = '0;
        j       = 0;
        for (int k = NUM_REQ - 1; k >= 0; k--) begin
            j = (int'(rr_ptr) + k) % NUM_REQ;
            if (req[j]) begin
                any_req = 1'b1;
                sel     = IDX_W'(j);
            end
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - round-robin share of one memory port among NUM_REQ agents
module mem_port_arbiter
    import mem_arb_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int ADDR_WIDTH = 4,
    parameter int NUM_REQ    = 2,
    parameter int TIMEOUT    = 16
) (
    input  logic                                clk,
    input  logic                                rst,
    input  logic [NUM_REQ-1:0]                  req_valid,
    input  logic [NUM_REQ-1:0]                  req_wt_rd,
    input  logic [NUM_REQ*ADDR_WIDTH-1:0]       req_addr,
    input  logic [NUM_REQ*WIDTH-1:0]            req_wdata,
    output logic [NUM_REQ-1:0]                  req_ready,
    output logic [WIDTH-1:0]                    rsp_rdata,
    output logic                                rsp_err,
    output logic [calc_idx_w(NUM_REQ)-1:0]      gnt_id,
    output logic                                busy,
    output logic                                mem_valid,
    output logic                                mem_wt_rd,
    output logic [ADDR_WIDTH-1:0]               mem_addr,
    output logic [WIDTH-1:0]                    mem_wdata,
    input  logic                                mem_ready,
    input  logic [WIDTH-1:0]                    mem_rdata
);

    localparam int IDX_W = calc_idx_w(NUM_REQ);
    localparam int TMR_W = calc_tmr_w(TIMEOUT);

    arb_state_e        state, state_d;
    logic [IDX_W-1:0]  rr_ptr, rr_ptr_d;
    logic [TMR_W-1:0]  timer, timer_d;
    logic [IDX_W-1:0]  gnt_id_d;
    logic              busy_d, mem_valid_d, mem_wt_rd_d, rsp_err_d;
    logic [ADDR_WIDTH-1:0] mem_addr_d;
    logic [WIDTH-1:0]  mem_wdata_d, rsp_rdata_d;
    logic [NUM_REQ-1:0] req_ready_d;
    logic              any_req;
    logic [IDX_W-1:0]  pick;

    mem_rr_picker #(.NUM_REQ(NUM_REQ), .IDX_W(IDX_W)) u_picker (
        .req     (req_valid),
        .rr_ptr  (rr_ptr),
        .any_req (any_req),
        .sel     (pick)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= IDLE;
            rr_ptr    <= '0;
            timer     <= '0;
            gnt_id    <= '0;
            busy      <= 1'b0;
            mem_valid <= 1'b0;
            mem_wt_rd <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            req_ready <= '0;
            rsp_rdata <= '0;
            rsp_err   <= 1'b0;
        end else begin
            state     <= state_d;
            rr_ptr    <= rr_ptr_d;
            timer     <= timer_d;
            gnt_id    <= gnt_id_d;
            busy      <= busy_d;
            mem_valid <= mem_valid_d;
            mem_wt_rd <= mem_wt_rd_d;
            mem_addr  <= mem_addr_d;
            mem_wdata <= mem_wdata_d;
            req_ready <= req_ready_d;
            rsp_rdata <= rsp_rdata_d;
            rsp_err   <= rsp_err_d;
        end
    end

    always_comb begin
        state_d     = state;
        rr_ptr_d    = rr_ptr;
        timer_d     = timer;
        gnt_id_d    = gnt_id;
        mem_valid_d = mem_valid;
        mem_wt_rd_d = mem_wt_rd;
        mem_addr_d  = mem_addr;
        mem_wdata_d = mem_wdata;
        req_ready_d = '0;
        rsp_rdata_d = rsp_rdata;
        rsp_err_d   = rsp_err;
        case (state)
            IDLE: begin
                if (any_req) begin
                    gnt_id_d    = pick;
                    mem_valid_d = 1'b1;
                    mem_wt_rd_d = req_wt_rd[pick];
                    mem_addr_d  = req_addr[pick*ADDR_WIDTH +: ADDR_WIDTH];
                    mem_wdata_d = req_wdata[pick*WIDTH +: WIDTH];
                    timer_d     = '0;
                    state_d     = ISSUE;
                end
            end
            ISSUE: begin
                // A handshake in the last allowed cycle still counts as success.
                if (mem_ready) begin
                    mem_valid_d         = 1'b0;
                    rsp_rdata_d         = mem_wt_rd ? '0 : mem_rdata;
                    rsp_err_d           = 1'b0;
                    req_ready_d[gnt_id] = 1'b1;
                    state_d             = DONE;
                end else if (timer == TMR_W'(TIMEOUT - 1)) begin
                    mem_valid_d         = 1'b0;
                    rsp_rdata_d         = '0;
                    rsp_err_d           = 1'b1;
                    req_ready_d[gnt_id] = 1'b1;
                    state_d             = DONE;
                end else begin
                    timer_d = timer + TMR_W'(1);
                end
            end
            DONE: begin
                rr_ptr_d  = (int'(gnt_id) == NUM_REQ - 1) ? '0 : gnt_id + IDX_W'(1);
                rsp_err_d = 1'b0;
                state_d   = IDLE;
            end
            default: state_d = IDLE;
        endcase
        busy_d = (state_d != IDLE);
    end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - directed self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;

    logic        clk = 1'b0;
    logic        rst;
    logic [1:0]  req_valid, req_wt_rd, req_ready;
    logic [7:0]  req_addr;
    logic [15:0] req_wdata;
    logic [7:0]  rsp_rdata, mem_wdata, mem_rdata;
    logic        rsp_err, busy, mem_valid, mem_wt_rd, mem_ready;
    logic [0:0]  gnt_id;
    logic [3:0]  mem_addr;
    logic [7:0]  mem [16];

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    mem_port_arbiter #(.WIDTH(8), .ADDR_WIDTH(4), .NUM_REQ(2), .TIMEOUT(16)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_wt_rd(req_wt_rd), .req_addr(req_addr), .req_wdata(req_wdata),
        .req_ready(req_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err), .gnt_id(gnt_id),
        .busy(busy), .mem_valid(mem_valid), .mem_wt_rd(mem_wt_rd), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_ready(mem_ready), .mem_rdata(mem_rdata)
    );

    always @(posedge clk)
        if (mem_valid && mem_ready && mem_wt_rd) mem[mem_addr] <= mem_wdata;
    assign mem_rdata = mem[mem_addr];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic do_req(input int a, input logic wt, input logic [3:0] addr, input logic [7:0] data,
                          output int lat, output logic [1:0] rr, output logic [7:0] rdata,
                          output logic err);
        bit got = 0;
        req_valid[a] = 1'b1;
        req_wt_rd[a] = wt;
        req_addr[a*4 +: 4] = addr;
        req_wdata[a*8 +: 8] = data;
        lat = 0;
        while (!got && lat < 40) begin
            tick();
            lat++;
            if (req_ready != 2'b00) got = 1;
        end
        rr = req_ready;
        rdata = rsp_rdata;
        err = rsp_err;
        req_valid[a] = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    initial begin
        int lat, cnt, seen;
        logic [1:0] rr;
        logic [7:0] rd;
        logic err;

        rst = 1'b1; req_valid = '0; req_wt_rd = '0; req_addr = '0; req_wdata = '0; mem_ready = 1'b0;
        tick(); tick();
        chk("reset_outputs", {req_ready, rsp_rdata, rsp_err, gnt_id, busy, mem_valid, mem_wt_rd, mem_addr, mem_wdata}, 0);
        rst = 1'b0;

        // 1: async reset in the middle of a stalled transaction
        req_valid[1] = 1'b1; req_wt_rd[1] = 1'b1; req_addr[7:4] = 4'hB; req_wdata[15:8] = 8'h77;
        tick();
        chk("t1_issue_valid", {mem_valid, busy, gnt_id, mem_addr}, {1'b1, 1'b1, 1'b1, 4'hB});
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("t1_async_clear", {req_ready, rsp_rdata, rsp_err, gnt_id, busy, mem_valid, mem_wt_rd, mem_addr, mem_wdata}, 0);
        req_valid = '0;
        tick();
        rst = 1'b0;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (req_ready != 2'b00 || busy) seen++;
        end
        chk("t1_no_ready_after", seen, 0);

        // 2: write then read back through agent 0
        mem_ready = 1'b1;
        do_req(0, 1'b1, 4'h3, 8'hA5, lat, rr, rd, err);
        chk("t2_wr_latency", lat, 2);
        chk("t2_wr_ready", {rr, err, rd}, {2'b01, 1'b0, 8'h00});
        chk("t2_mem_written", mem[3], 8'hA5);
        tick();
        chk("t2_ready_cleared", {req_ready, busy}, 0);
        do_req(0, 1'b0, 4'h3, 8'h00, lat, rr, rd, err);
        chk("t2_rd_latency", lat, 2);
        chk("t2_rd_data", {rr, err, rd}, {2'b01, 1'b0, 8'hA5});
        tick();
        do_req(0, 1'b1, 4'h7, 8'hC3, lat, rr, rd, err);
        chk("t2_wr7_ready", rr, 2'b01);
        tick();

        // 3: contention from reset alternates 0,1,0,1
        do_reset();
        req_valid = 2'b11; req_wt_rd = 2'b11; req_addr = 8'h21; req_wdata = 16'h2211;
        for (int n = 0; n < 4; n++) begin
            cnt = 0;
            while (req_ready == 2'b00 && cnt < 20) begin
                tick();
                cnt++;
            end
            chk($sformatf("t3_ready_%0d", n), req_ready, (n % 2 == 0) ? 2'b01 : 2'b10);
            chk($sformatf("t3_gnt_%0d", n), gnt_id, n % 2);
            tick();
        end
        req_valid = '0;
        tick();
        chk("t3_mem_contents", {mem[1], mem[2]}, 16'h1122);

        // 4: five stall cycles keep the request stable, ready one cycle after handshake
        mem_ready = 1'b0;
        req_valid[0] = 1'b1; req_wt_rd[0] = 1'b1; req_addr[3:0] = 4'h5; req_wdata[7:0] = 8'h3C;
        tick();
        seen = 0;
        for (int i = 0; i < 6; i++) begin
            if (mem_valid && mem_addr == 4'h5 && mem_wdata == 8'h3C && req_ready == 2'b00) seen++;
            if (i == 5) mem_ready = 1'b1;
            tick();
        end
        chk("t4_stable_cycles", seen, 6);
        chk("t4_ready_after", {req_ready, mem_valid}, {2'b01, 1'b0});
        req_valid = '0;
        tick();
        chk("t4_ready_one_cycle", req_ready, 2'b00);
        chk("t4_mem_written", mem[5], 8'h3C);

        // 5: timeout with stuck ready, then a normal read from the same agent
        mem_ready = 1'b0;
        req_valid[1] = 1'b1; req_wt_rd[1] = 1'b0; req_addr[7:4] = 4'h7;
        tick();
        cnt = 0;
        while (mem_valid && cnt < 40) begin
            cnt++;
            tick();
        end
        chk("t5_valid_cycles", cnt, 16);
        chk("t5_err_ready", {req_ready, rsp_err, rsp_rdata}, {2'b10, 1'b1, 8'h00});
        req_valid = '0;
        tick();
        chk("t5_err_cleared", {req_ready, rsp_err}, 0);
        mem_ready = 1'b1;
        do_req(1, 1'b0, 4'h7, 8'h00, lat, rr, rd, err);
        chk("t5_recover", {rr, err, rd}, {2'b10, 1'b0, 8'hC3});
        chk("t5_recover_lat", lat, 2);
        tick();

        // 6: agent 1 drops its request right after grant
        mem_ready = 1'b0;
        req_valid[1] = 1'b1; req_wt_rd[1] = 1'b1; req_addr[7:4] = 4'h9; req_wdata[15:8] = 8'h96;
        tick();
        chk("t6_granted", {gnt_id, mem_valid, mem_addr}, {1'b1, 1'b1, 4'h9});
        req_valid[1] = 1'b0; req_addr[7:4] = 4'h0; req_wdata[15:8] = 8'h00;
        tick();
        chk("t6_held", {mem_valid, mem_addr, mem_wdata}, {1'b1, 4'h9, 8'h96});
        mem_ready = 1'b1;
        tick();
        chk("t6_ready", req_ready, 2'b10);
        chk("t6_mem_written", mem[9], 8'h96);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
